// File: rtl/pc_stack_unit.sv
// Program-counter unit with HOLD/INC/REL/ABS update and a hardware return-address stack.
// Sticky ovf/unf flags record pushes onto a full stack and pops from an empty one.
module pc_stack_unit #(
  parameter int unsigned     AW        = 16,
  parameter int unsigned     DEPTH     = 8,
  parameter logic [AW-1:0]   RESET_VEC = 16'h0000,
  localparam int unsigned    PW        = $clog2(DEPTH),
  localparam int unsigned    DW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    pc_sel,
  input  logic [7:0]    rel_off,
  input  logic [AW-1:0] abs_addr,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  typedef enum logic [1:0] {
    PS_HOLD = 2'd0,
    PS_INC  = 2'd1,
    PS_REL  = 2'd2,
    PS_ABS  = 2'd3
  } ps_t;

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [AW-1:0] stack_mem [DEPTH];

  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] rel_ext;
  logic [AW-1:0] sel_pc;
  logic [PW-1:0] push_idx;
  logic [PW-1:0] top_idx;
  logic [AW-1:0] top_val;
  logic          empty_w;
  logic          full_w;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic          ovf_err;
  logic          unf_err;

  assign pc_plus1 = pc_q + AW'(1);
  assign rel_ext  = AW'($signed(rel_off));
  assign empty_w  = (depth_q == '0);
  assign full_w   = (depth_q == DW'(DEPTH));
  assign push_idx = depth_q[PW-1:0];
  assign top_idx  = depth_q[PW-1:0] - PW'(1);
  assign top_val  = stack_mem[top_idx];

  always_comb begin
    sel_pc = pc_q;
    case (ps_t'(pc_sel))
      PS_HOLD: sel_pc = pc_q;
      PS_INC:  sel_pc = pc_plus1;
      PS_REL:  sel_pc = pc_q + rel_ext;
      PS_ABS:  sel_pc = abs_addr;
      default: sel_pc = pc_q;
    endcase
  end

  // An effective pop (non-empty) owns the PC; a simultaneous push then becomes a swap of the top.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_addr = push_idx;
    ovf_err = push && full_w && !pop;
    unf_err = pop && empty_w;

    if (pop && !empty_w) begin
      pc_d = top_val;
      if (push) begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end else begin
        depth_d = depth_q - DW'(1);
      end
    end else begin
      pc_d = sel_pc;
      if (push && !full_w) begin
        wr_en   = 1'b1;
        wr_addr = push_idx;
        depth_d = depth_q + DW'(1);
      end
    end

    ovf_d = (ovf_q && !clr_err) || ovf_err;
    unf_d = (unf_q && !clr_err) || unf_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is not reset; only depth defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_mem[wr_addr] <= pc_plus1;
    end
  end

  assign pc    = pc_q;
  assign depth = depth_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: a driver updates a queue-based stack model and
// queues expected outputs; a monitor compares them one cycle later.
module tb_pc_stack_unit;

  localparam logic [15:0] RVEC = 16'hFFFC;
  localparam int          DEP  = 8;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [7:0]  rel_off = 8'd0;
  logic [15:0] abs_addr = 16'd0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] pc_w;
  logic [3:0]  depth_w;
  logic        empty_w, full_w, ovf_w, unf_w;

  obs_t dut_obs;
  assign dut_obs = {pc_w, depth_w, empty_w, full_w, ovf_w, unf_w};

  int n_vec = 0;
  int n_bad = 0;
  obs_t exp_q[$];

  // Reference model state
  int unsigned m_pc;
  logic [15:0] m_stk[$];
  bit          m_ovf, m_unf;

  pc_stack_unit #(.AW(16), .DEPTH(DEP), .RESET_VEC(RVEC)) dut (
    .clk(clk), .reset_n(reset_n), .pc_sel(pc_sel), .rel_off(rel_off),
    .abs_addr(abs_addr), .push(push), .pop(pop), .clr_err(clr_err),
    .pc(pc_w), .depth(depth_w), .empty(empty_w), .full(full_w),
    .ovf(ovf_w), .unf(unf_w)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_obs();
    obs_t o;
    o.pc    = 16'(m_pc);
    o.depth = 4'(m_stk.size());
    o.empty = (m_stk.size() == 0);
    o.full  = (m_stk.size() == DEP);
    o.ovf   = m_ovf;
    o.unf   = m_unf;
    return o;
  endfunction

  task automatic model_reset();
    m_pc = RVEC;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input logic [1:0] s, input logic [7:0] r, input logic [15:0] a,
                            input bit pu, input bit po, input bit ce);
    int unsigned ret_addr, next_pc;
    bit oerr, uerr;
    ret_addr = (m_pc + 1) % 65536;
    oerr = 0;
    uerr = 0;
    case (s)
      2'd0: next_pc = m_pc;
      2'd1: next_pc = ret_addr;
      2'd2: next_pc = int'(unsigned'(int'(m_pc) + int'($signed(r)) + 65536)) % 65536;
      default: next_pc = a;
    endcase
    if (po && m_stk.size() > 0) begin
      next_pc = m_stk.pop_back();
      if (pu) m_stk.push_back(16'(ret_addr));
    end else begin
      if (po) uerr = 1;
      if (pu) begin
        if (m_stk.size() < DEP) m_stk.push_back(16'(ret_addr));
        else oerr = 1;
      end
    end
    m_pc  = next_pc;
    m_ovf = (m_ovf && !ce) || oerr;
    m_unf = (m_unf && !ce) || uerr;
  endtask

  task automatic drive(input logic [1:0] s, input logic [7:0] r, input logic [15:0] a,
                       input bit pu, input bit po, input bit ce);
    @(negedge clk);
    pc_sel = s; rel_off = r; abs_addr = a; push = pu; pop = po; clr_err = ce;
    model_step(s, r, a, pu, po, ce);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle_inputs();
    pc_sel = 2'd0; rel_off = 8'd0; abs_addr = 16'd0; push = 0; pop = 0; clr_err = 0;
  endtask

  task automatic check_now(input string name);
    obs_t e;
    e = model_obs();
    n_vec++;
    if (dut_obs !== e) begin
      n_bad++;
      $display("FAIL %s: got pc=%h depth=%0d e=%b f=%b ovf=%b unf=%b, want pc=%h depth=%0d e=%b f=%b ovf=%b unf=%b",
               name, dut_obs.pc, dut_obs.depth, dut_obs.empty, dut_obs.full, dut_obs.ovf, dut_obs.unf,
               e.pc, e.depth, e.empty, e.full, e.ovf, e.unf);
    end else begin
      $display("%s: ok pc=%h depth=%0d", name, dut_obs.pc, dut_obs.depth);
    end
  endtask

  // Monitor: one expected value per clock edge that followed a driven cycle
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (dut_obs !== e) begin
          n_bad++;
          $display("FAIL vec%0d: got pc=%h depth=%0d e=%b f=%b ovf=%b unf=%b, want pc=%h depth=%0d e=%b f=%b ovf=%b unf=%b",
                   n_vec, dut_obs.pc, dut_obs.depth, dut_obs.empty, dut_obs.full, dut_obs.ovf, dut_obs.unf,
                   e.pc, e.depth, e.empty, e.full, e.ovf, e.unf);
        end else begin
          $display("vec%0d: ok pc=%h depth=%0d ovf=%b unf=%b", n_vec, dut_obs.pc, dut_obs.depth,
                   dut_obs.ovf, dut_obs.unf);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check_now("reset_state");

    // Increment through the top of the address space
    repeat (4) drive(2'd1, 8'h00, 16'h0000, 0, 0, 0);

    // Relative and absolute jumps
    drive(2'd3, 8'h00, 16'h1000, 0, 0, 0);
    drive(2'd2, 8'h10, 16'h0000, 0, 0, 0);
    drive(2'd2, 8'hF0, 16'h0000, 0, 0, 0);
    drive(2'd3, 8'h00, 16'h8000, 0, 0, 0);
    drive(2'd3, 8'h00, 16'h0002, 0, 0, 0);
    drive(2'd2, 8'hFC, 16'h0000, 0, 0, 0);

    // JSR then RTS
    drive(2'd3, 8'h00, 16'h0200, 0, 0, 0);
    drive(2'd3, 8'h00, 16'h0300, 1, 0, 0);
    drive(2'd3, 8'h00, 16'h7777, 0, 1, 0);

    // Fill, overflow, clear
    for (int i = 0; i < DEP; i++) drive(2'd1, 8'h00, 16'h0000, 1, 0, 0);
    drive(2'd3, 8'h00, 16'h1234, 1, 0, 0);
    drive(2'd0, 8'h00, 16'h0000, 0, 0, 1);
    drive(2'd1, 8'h00, 16'h0000, 1, 1, 0);
    for (int i = 0; i < DEP; i++) drive(2'd1, 8'h00, 16'h0000, 0, 1, 0);

    // Underflow, error clear racing a new error, swap
    drive(2'd3, 8'h00, 16'h0010, 0, 0, 0);
    drive(2'd1, 8'h00, 16'h0000, 0, 1, 0);
    drive(2'd0, 8'h00, 16'h0000, 0, 1, 1);
    drive(2'd0, 8'h00, 16'h0000, 0, 0, 1);
    drive(2'd1, 8'h00, 16'h0000, 1, 1, 0);
    drive(2'd0, 8'h00, 16'h0000, 0, 1, 0);
    drive(2'd3, 8'h00, 16'h03FF, 0, 0, 1);
    drive(2'd3, 8'h00, 16'h0050, 1, 0, 0);
    drive(2'd2, 8'h40, 16'h0000, 1, 1, 0);
    drive(2'd0, 8'h00, 16'h0000, 0, 1, 0);

    // Asynchronous reset mid-cycle with a partly filled stack
    for (int i = 0; i < 5; i++) drive(2'd1, 8'h00, 16'h0000, 1, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_now("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_now("reset_release");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom),
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 8));
    end

    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
